// File: rtl/step_counter_bank_if.sv
// Command and status bundle for step_counter_bank: per-channel controls,
// the shared load value, and the packed counter/flag outputs.
interface step_counter_bank_if #(
  parameter int width    = 8,
  parameter int channels = 2
);
  logic [channels-1:0]       en;
  logic [channels-1:0]       dir;
  logic [channels-1:0]       clr;
  logic [channels-1:0]       load;
  logic [width-1:0]          load_val;
  logic [channels*width-1:0] out;
  logic [channels-1:0]       ovf;
  logic [channels-1:0]       sat;

  modport master (
    output en, dir, clr, load, load_val,
    input  out, ovf, sat
  );

  modport slave (
    input  en, dir, clr, load, load_val,
    output out, ovf, sat
  );
endinterface

// File: rtl/step_counter_bank.sv
// Bank of independent up/down step counters with wrap or saturate arithmetic,
// per-channel clear/load/enable (in that priority), a one-cycle ovf pulse and
// a sticky saturation flag.
module step_counter_bank #(
  parameter int width    = 8,
  parameter int step     = 1,
  parameter int channels = 2,
  parameter int saturate = 0,
  parameter int init     = 0
) (
  input logic clk,
  input logic rst,
  step_counter_bank_if.slave bus
);

  localparam logic [width-1:0] step_w = width'(step);
  localparam logic [width-1:0] init_w = width'(init);
  localparam bit               sat_en = (saturate != 0);

  for (genvar i = 0; i < channels; i++) begin : g_ch
    logic [width-1:0] cnt_q;
    logic [width-1:0] nxt;
    logic [width:0]   s_up;
    logic [width-1:0] s_dn;
    logic             ovf_c;
    logic             ovf_q;
    logic             sat_q;

    // The carry out of the widened sum flags an up overflow; a borrow occurs
    // exactly when the current value is below the step.
    assign s_up  = {1'b0, cnt_q} + {1'b0, step_w};
    assign s_dn  = cnt_q - step_w;
    assign ovf_c = bus.dir[i] ? (cnt_q < step_w) : s_up[width];

    // Next counting value: wrapped result, or pinned to the rail when clamping.
    always_comb begin
      nxt = bus.dir[i] ? s_dn : s_up[width-1:0];
      if (sat_en && ovf_c) begin
        nxt = bus.dir[i] ? '0 : '1;
      end
    end

    // Channel state: clear beats load beats count; idle cycles drop the pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= init_w;
        ovf_q <= 1'b0;
        sat_q <= 1'b0;
      end else if (bus.clr[i]) begin
        cnt_q <= init_w;
        ovf_q <= 1'b0;
        sat_q <= 1'b0;
      end else if (bus.load[i]) begin
        cnt_q <= bus.load_val;
        ovf_q <= 1'b0;
      end else if (bus.en[i]) begin
        cnt_q <= nxt;
        ovf_q <= ovf_c;
        sat_q <= sat_q | (sat_en & ovf_c);
      end else begin
        ovf_q <= 1'b0;
      end
    end

    assign bus.out[i*width +: width] = cnt_q;
    assign bus.ovf[i]                = ovf_q;
    assign bus.sat[i]                = sat_en ? sat_q : 1'b0;
  end

endmodule

// File: tb/tb_step_counter_bank.sv
// Directed checks for step_counter_bank across several parameterisations,
// including named, positional and defparam overrides driven identically.
module tb_step_counter_bank;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  step_counter_bank_if #(.width(8), .channels(2)) if_a ();
  step_counter_bank_if #(.width(8), .channels(2)) if_b ();
  step_counter_bank_if #(.width(8), .channels(2)) if_c ();
  step_counter_bank_if #(.width(4), .channels(2)) if_w ();
  step_counter_bank_if #(.width(4), .channels(2)) if_p ();
  step_counter_bank_if #(.width(4), .channels(2)) if_d ();
  step_counter_bank_if #(.width(4), .channels(2)) if_s ();
  step_counter_bank_if #(.width(1), .channels(1)) if_o ();

  step_counter_bank                               u_a (.clk(clk), .rst(rst), .bus(if_a));
  step_counter_bank #(.init(3))                   u_b (.clk(clk), .rst(rst), .bus(if_b));
  step_counter_bank #(.init(9))                   u_c (.clk(clk), .rst(rst), .bus(if_c));
  step_counter_bank #(.width(4), .step(7))        u_w (.clk(clk), .rst(rst), .bus(if_w));
  step_counter_bank #(4, 7)                       u_p (.clk(clk), .rst(rst), .bus(if_p));
  step_counter_bank                               u_d (.clk(clk), .rst(rst), .bus(if_d));
  defparam u_d.width = 4;
  defparam u_d.step  = 7;
  step_counter_bank #(.width(4), .step(7), .saturate(1)) u_s (.clk(clk), .rst(rst), .bus(if_s));
  step_counter_bank #(.width(1), .channels(1))    u_o (.clk(clk), .rst(rst), .bus(if_o));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus goes to all three 4-bit wrap instances; all must match one trace.
  task automatic drive_wpd(input logic [1:0] load, input logic [1:0] en, input logic [3:0] lv);
    if_w.load = load; if_p.load = load; if_d.load = load;
    if_w.en   = en;   if_p.en   = en;   if_d.en   = en;
    if_w.load_val = lv; if_p.load_val = lv; if_d.load_val = lv;
  endtask

  task automatic chk_wpd(input string tag, input logic [7:0] out, input logic [1:0] ovf);
    check({tag, "_named_out"}, 32'(if_w.out), 32'(out));
    check({tag, "_named_ovf"}, 32'(if_w.ovf), 32'(ovf));
    check({tag, "_named_sat"}, 32'(if_w.sat), 32'd0);
    check({tag, "_pos_out"},   32'(if_p.out), 32'(out));
    check({tag, "_pos_ovf"},   32'(if_p.ovf), 32'(ovf));
    check({tag, "_pos_sat"},   32'(if_p.sat), 32'd0);
    check({tag, "_defp_out"},  32'(if_d.out), 32'(out));
    check({tag, "_defp_ovf"},  32'(if_d.ovf), 32'(ovf));
    check({tag, "_defp_sat"},  32'(if_d.sat), 32'd0);
  endtask

  task automatic chk_s(input string tag, input logic [3:0] out0, input logic ovf0, input logic sat0);
    check({tag, "_out"}, 32'(if_s.out), {24'd0, 4'd0, out0});
    check({tag, "_ovf"}, 32'(if_s.ovf), {30'd0, 1'b0, ovf0});
    check({tag, "_sat"}, 32'(if_s.sat), {30'd0, 1'b0, sat0});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    {if_a.en, if_a.dir, if_a.clr, if_a.load, if_a.load_val} = '0;
    {if_b.en, if_b.dir, if_b.clr, if_b.load, if_b.load_val} = '0;
    {if_c.en, if_c.dir, if_c.clr, if_c.load, if_c.load_val} = '0;
    {if_w.en, if_w.dir, if_w.clr, if_w.load, if_w.load_val} = '0;
    {if_p.en, if_p.dir, if_p.clr, if_p.load, if_p.load_val} = '0;
    {if_d.en, if_d.dir, if_d.clr, if_d.load, if_d.load_val} = '0;
    {if_s.en, if_s.dir, if_s.clr, if_s.load, if_s.load_val} = '0;
    {if_o.en, if_o.dir, if_o.clr, if_o.load, if_o.load_val} = '0;
    #12;
    check("rst_a_out", 32'(if_a.out), 32'h0000);
    check("rst_a_ovf", 32'(if_a.ovf), 32'd0);
    check("rst_b_out", 32'(if_b.out), 32'h0303);
    check("rst_c_out", 32'(if_c.out), 32'h0909);
    check("rst_s_sat", 32'(if_s.sat), 32'd0);

    // Default bank: channel 0 walks through a full wrap, channel 1 idle.
    @(negedge clk);
    rst = 1'b0;
    if_a.en = 2'b01;
    for (int n = 1; n <= 260; n++) begin
      tick();
      check("walk_out", 32'(if_a.out), {16'd0, 8'd0, 8'(n)});
      check("walk_ovf", 32'(if_a.ovf), {30'd0, 1'b0, (n == 256)});
    end
    if_a.en = 2'b00;

    // 4-bit step 7 wrap on channel 1, three override styles.
    drive_wpd(2'b10, 2'b00, 4'd12);
    tick(); chk_wpd("wrap_load", {4'd12, 4'd0}, 2'b00);
    drive_wpd(2'b00, 2'b10, 4'd0);
    tick(); chk_wpd("wrap_s1", {4'd3,  4'd0}, 2'b10);
    tick(); chk_wpd("wrap_s2", {4'd10, 4'd0}, 2'b00);
    tick(); chk_wpd("wrap_s3", {4'd1,  4'd0}, 2'b10);
    tick(); chk_wpd("wrap_s4", {4'd8,  4'd0}, 2'b00);
    drive_wpd(2'b00, 2'b00, 4'd0);
    tick(); chk_wpd("wrap_idle", {4'd8, 4'd0}, 2'b00);

    // 4-bit step 7 saturating on channel 0.
    if_s.load = 2'b01; if_s.load_val = 4'd10;
    tick(); chk_s("sat_load", 4'd10, 1'b0, 1'b0);
    if_s.load = 2'b00; if_s.en = 2'b01;
    tick(); chk_s("sat_up1", 4'd15, 1'b1, 1'b1);
    tick(); chk_s("sat_up2", 4'd15, 1'b1, 1'b1);
    if_s.dir = 2'b01;
    tick(); chk_s("sat_dn1", 4'd8, 1'b0, 1'b1);
    tick(); chk_s("sat_dn2", 4'd1, 1'b0, 1'b1);
    tick(); chk_s("sat_dn3", 4'd0, 1'b1, 1'b1);
    if_s.en = 2'b00; if_s.dir = 2'b00; if_s.clr = 2'b01;
    tick(); chk_s("sat_clr", 4'd0, 1'b0, 1'b0);
    if_s.clr = 2'b00;

    // Width-1 toggle: ovf on every 1->0.
    if_o.en = 1'b1;
    tick(); check("w1_out1", 32'(if_o.out), 32'd1); check("w1_ovf1", 32'(if_o.ovf), 32'd0);
    tick(); check("w1_out2", 32'(if_o.out), 32'd0); check("w1_ovf2", 32'(if_o.ovf), 32'd1);
    tick(); check("w1_out3", 32'(if_o.out), 32'd1); check("w1_ovf3", 32'(if_o.ovf), 32'd0);
    tick(); check("w1_out4", 32'(if_o.out), 32'd0); check("w1_ovf4", 32'(if_o.ovf), 32'd1);
    if_o.en = 1'b0;

    // Priority clr > load > en with init 3.
    if_b.clr = 2'b01; if_b.load = 2'b01; if_b.en = 2'b01; if_b.load_val = 8'h55;
    tick(); check("pri_clr", 32'(if_b.out), 32'h0303);
    if_b.clr = 2'b00;
    tick(); check("pri_load", 32'(if_b.out), 32'h0355);
    check("pri_load_ovf", 32'(if_b.ovf), 32'd0);
    if_b.load = 2'b00;
    tick(); check("pri_en", 32'(if_b.out), 32'h0356);
    if_b.en = 2'b00;

    // Asynchronous reset with init 9 while both channels count and ovf is high.
    if_c.load = 2'b11; if_c.load_val = 8'hFF;
    tick(); check("ar_load", 32'(if_c.out), 32'hFFFF);
    if_c.load = 2'b00; if_c.en = 2'b11;
    tick(); check("ar_wrap_out", 32'(if_c.out), 32'h0000);
    check("ar_wrap_ovf", 32'(if_c.ovf), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("ar_async_out", 32'(if_c.out), 32'h0909);
    check("ar_async_ovf", 32'(if_c.ovf), 32'd0);
    check("ar_async_sat", 32'(if_c.sat), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar_hold_out", 32'(if_c.out), 32'h0909);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(); check("ar_resume", 32'(if_c.out), 32'h0A0A);
    check("ar_resume_ovf", 32'(if_c.ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_counter_bank.md
Name: step_counter_bank

Overview:
- Registered, multi-channel successor to the combinational parametrised incrementer.
- Holds CHANNELS independent WIDTH-bit counters. On each enabled cycle, a counter moves up or down by STEP, with either modulo-wrap or saturating arithmetic.
- Serves as a parameter-override test vehicle (named, positional and defparam overrides) with real sequential state.

Parameters:
- width, 8, bit width of each channel counter (1..32).
- step, 1, increment/decrement magnitude. Legal range is 0..2^width-1; step is truncated to width bits.
- channels, 2, number of independent counter channels (1..8).
- saturate, 0, arithmetic mode. 0 = modulo 2^width wrap; 1 = clamp at 0 and 2^width-1.
- init, 0, reset and clear value of every channel, truncated to width bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  channels  per-channel count enable.
- dir  input  channels  per-channel direction. 0 = up (+step), 1 = down (-step).
- clr  input  channels  per-channel synchronous clear to init.
- load  input  channels  per-channel synchronous load of load_val.
- load_val  input  width  shared load value, applied to every channel whose load bit is set.
- out  output  channels*width  packed counter values. Channel i occupies out[i*width +: width].
- ovf  output  channels  per-channel one-cycle overflow/underflow pulse.
- sat  output  channels  per-channel sticky saturation flag (saturate=1 only; constant 0 otherwise).

Behaviour:
- Reset:
  - rst high forces every out slice to init, ovf to 0 and sat to 0 immediately, with no clock needed.
  - Values hold while rst is high.
  - Deassertion takes effect at the next rising edge.
- Update latency: all updates are registered. A command sampled on edge N is visible on out after edge N.
- Per-channel priority each cycle: clr > load > en > hold.
  - clr: out_i <= init; ovf_i <= 0; sat_i <= 0.
  - load: out_i <= load_val; ovf_i <= 0; sat_i unchanged.
  - en: out_i <= next_i (rules below); ovf_i <= overflow condition; sat_i |= clamp event.
  - hold: out_i unchanged; ovf_i <= 0.
- Arithmetic: computed in width+1 bits. Up: s = out_i + step. Down: s = out_i - step.
  - Overflow condition: up with s >= 2^width; down with out_i < step.
  - saturate=0: next_i = s mod 2^width; ovf_i pulses on the overflow condition.
  - saturate=1, overflow condition true:
    - next_i = 2^width-1 (up) or 0 (down).
    - ovf_i pulses for one cycle.
    - sat_i sets and stays set until clr_i or rst.
  - saturate=1 at a rail: a channel already at the rail that keeps counting into it re-pulses ovf every enabled cycle and stays at the rail.
- step=0: en has no effect on value; ovf is never asserted.
- Channels are fully independent. Simultaneous events on different channels in the same cycle are all honoured.
- ovf is a pure pulse: it is 0 on any cycle following a non-counting or non-overflowing update.
- width=1 is legal. With step=1, saturate=0, the counter toggles and ovf pulses on every 1->0 up transition.
- Reset asserted mid-count discards any in-flight update on that edge; the asynchronous reset wins.

Test Plan:
- Defaults, en[0]=1, dir=0 for 260 cycles from reset:
  - out[7:0] walks 0,1,...,255,0,1,...
  - ovf[0] is high exactly on the cycle out[7:0] becomes 0 after 255 (cycles 256 and never again before 512).
  - Channel 1 stays 0 throughout.
- width=4, step=7, saturate=0, load[1] with load_val=4'd12, then en[1]=1 up:
  - out[7:4] sequence 12, 3 (ovf pulse), 10, 1 (ovf pulse), 8.
- width=4, step=7, saturate=1, load value 10, up:
  - out goes 10 -> 15, with ovf and sat both asserted.
  - A further en keeps 15 and re-pulses ovf; sat stays 1.
  - dir=1 for three cycles: 8, 1, then 0 with ovf pulse.
  - clr clears sat.
- Priority: same-cycle clr[0]=1, load[0]=1, en[0]=1 with load_val=0x55 and init=3 -> out[7:0]=3.
  - Next cycle load[0]=1, en[0]=1 -> out[7:0]=0x55 and ovf[0]=0.
- Async reset, init=9: drive rst high between clock edges while both channels are counting.
  - out becomes {8'd9,8'd9} and ovf/sat become 0 before the next edge.
  - Values hold for the whole time rst is high.
  - Counting resumes from 9 on the first edge after deassertion.
- Override equivalence: instantiate step_counter_bank #(.width(4), .step(7)), #(4,7) and via defparam with identical stimulus.
  - All three produce identical out/ovf/sat traces.
